prm_mask_responder: RTL and testbench
=====================================

Name: prm_mask_responder

Overview:
Responder end of the coordinate/edge-mask check interface. Accepts one packed XYZ coordinate request, drives x/y/z to the edge-mask LUT fabric, and waits a fixed settle interval to cover the buffered global-net path. It then captures the 512-bit edge mask and streams it back as 32-bit beats over a valid/ready channel, reporting the mask popcount at the end.

Parameters:
XW, 4, x coordinate width
YW, 5, y coordinate width
ZW, 5, z coordinate width
MASKW, 512, edge mask width; must be a multiple of BEATW
BEATW, 32, response beat width
SETTLE, 2, cycles between x/y/z update and mask capture; legal range 1..15
NBEATS, MASKW/BEATW (16), derived, not overridable

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_xyz  in  XW+YW+ZW  packed request {x,y,z}, with x in the MSBs
x  out  XW  coordinate to LUT fabric (registered)
y  out  YW  coordinate to LUT fabric (registered)
z  out  ZW  coordinate to LUT fabric (registered)
edge_mask  in  MASKW  mask returned by LUT fabric
rsp_valid  out  1  response beat valid
rsp_ready  in  1  consumer accepts beat
rsp_data  out  BEATW  response beat
rsp_idx  out  4  beat index, 0..NBEATS-1
rsp_last  out  1  final beat of the mask
hit_cnt  out  10  popcount of last completed mask
hit_valid  out  1  one-cycle pulse when hit_cnt updates

Behaviour:
- Reset (asynchronous) values:
  - State goes to IDLE.
  - x, y, z, rsp_data, rsp_idx, hit_cnt and the accumulator are 0.
  - rsp_valid, rsp_last and hit_valid are 0.
  - req_ready is 1 as soon as RST deasserts, because req_ready = (state == IDLE).
- States: IDLE -> SETTLE -> SEND -> DONE -> IDLE.
- IDLE:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - On accept, {x,y,z} <= req_xyz, the settle counter is loaded with SETTLE, and the state moves to SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - On the edge where the counter reaches 1, the shadow register captures edge_mask and the state moves to SEND.
  - The mask is therefore sampled after x/y/z have been stable for exactly SETTLE cycles.
- SEND:
  - rsp_valid = 1, rsp_data = shadow[rsp_idx*BEATW +: BEATW], LSB beat first.
  - rsp_last = (rsp_idx == NBEATS-1).
  - On rsp_valid && rsp_ready: the accumulator adds popcount(rsp_data) and rsp_idx increments.
  - If that beat had rsp_last set, the state moves to DONE and rsp_idx returns to 0.
- Stall: while rsp_ready = 0, rsp_data, rsp_idx and rsp_last are held stable and rsp_valid stays high.
- DONE (one cycle): hit_cnt <= accumulator and hit_valid = 1. The accumulator clears, and the state returns to IDLE.
- hit_cnt holds its value until the next DONE.
- Latency with rsp_ready tied high:
  - Accept at edge 0, x/y/z valid from cycle 1, capture at edge SETTLE, first beat valid in cycle SETTLE+1.
  - Last beat in cycle SETTLE+NBEATS, hit_valid in cycle SETTLE+NBEATS+1, req_ready high again in cycle SETTLE+NBEATS+2.
- Boundary rules:
  - Changes on edge_mask after capture have no effect on the response.
  - req_valid while busy is not accepted (req_ready = 0), and req_xyz is ignored.
  - x/y/z hold the last accepted coordinate in all states until the next accept.
  - Reset mid-operation aborts: the partial response is discarded, no hit_valid is produced, and the accumulator is cleared.
  - Popcount width is 10 bits, so the maximum value 512 fits.

Test Plan:
- Reset values: assert RST mid-cycle -> all outputs read 0 asynchronously; after release req_ready = 1.
- Basic all-ones transaction: req_xyz = 14'h1ABC, edge_mask all ones, rsp_ready = 1.
  - x = 4'h6, y = 5'h15, z = 5'h1C from cycle 1.
  - 16 beats of 32'hFFFFFFFF, rsp_last only on rsp_idx = 15.
  - hit_cnt = 512 with hit_valid in cycle 19.
- Beat ordering: mask beat k = k (k = 0..15) -> rsp_data sequence 0,1,...,15 in order; hit_cnt = 32.
- Backpressure: rsp_ready toggles 1,0,0,1 repeating -> rsp_data/rsp_idx stable across stalls, no beat lost or duplicated; hit_cnt correct.
- Capture timing and busy rejection:
  - edge_mask changed to all zeros one cycle after capture -> response still carries the captured mask.
  - Second req_valid during SEND -> req_ready = 0 and x/y/z unchanged.
- Reset mid-operation: RST at rsp_idx = 7 -> immediate IDLE, no hit_valid, hit_cnt = 0.
  - A following request with mask = 0 -> hit_cnt = 0 with a clean 16-beat response.

Source files
------------

// File: rtl/prm_mask_responder.sv
// Responder for the coordinate/edge-mask check interface: drives x/y/z to the LUT
// fabric, waits out the settle interval, then streams the captured mask as beats.
module prm_mask_responder #(
    parameter int XW     = 4,
    parameter int YW     = 5,
    parameter int ZW     = 5,
    parameter int MASKW  = 512,
    parameter int BEATW  = 32,
    parameter int SETTLE = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [XW+YW+ZW-1:0]   req_xyz,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [ZW-1:0]         z,
    input  logic [MASKW-1:0]      edge_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BEATW-1:0]      rsp_data,
    output logic [3:0]            rsp_idx,
    output logic                  rsp_last,
    output logic [9:0]            hit_cnt,
    output logic                  hit_valid
);

    localparam int NBEATS = MASKW / BEATW;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state;
    logic [3:0]       settle_cnt;
    logic [MASKW-1:0] shadow;
    logic [9:0]       acc;
    logic [3:0]       idx;
    logic [9:0]       beat_sum;

    function automatic logic [9:0] beat_popcount(input logic [BEATW-1:0] v);
        logic [9:0] cnt;
        cnt = '0;
        for (int i = 0; i < BEATW; i++) begin
            cnt = cnt + 10'(v[i]);
        end
        return cnt;
    endfunction

    // req_ready is held low while reset is asserted so every output reads 0 during reset
    assign req_ready = (state == ST_IDLE) && !RST;
    assign rsp_valid = (state == ST_SEND);
    assign rsp_data  = shadow[idx*BEATW +: BEATW];
    assign rsp_idx   = idx;
    assign rsp_last  = rsp_valid && (idx == 4'(NBEATS - 1));
    assign hit_valid = (state == ST_DONE);
    assign beat_sum  = acc + beat_popcount(rsp_data);

    // hit_cnt is loaded on the final handshake so it is already valid in the DONE cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            shadow     <= '0;
            acc        <= '0;
            idx        <= '0;
            hit_cnt    <= '0;
            x          <= '0;
            y          <= '0;
            z          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        {x, y, z}  <= req_xyz;
                        settle_cnt <= 4'(SETTLE);
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        shadow <= edge_mask;
                        state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (rsp_ready) begin
                        if (rsp_last) begin
                            hit_cnt <= beat_sum;
                            acc     <= '0;
                            idx     <= '0;
                            state   <= ST_DONE;
                        end else begin
                            acc <= beat_sum;
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                    acc   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prm_mask_responder.sv
// Bench for prm_mask_responder: directed and randomized transactions checked
// against a reference model derived from mask shifts and $countones.
module tb_prm_mask_responder;

    localparam int XW     = 4;
    localparam int YW     = 5;
    localparam int ZW     = 5;
    localparam int MASKW  = 512;
    localparam int BEATW  = 32;
    localparam int SETTLE = 2;
    localparam int NB     = MASKW / BEATW;

    logic                CLK = 1'b0;
    logic                RST;
    logic                req_valid;
    logic                req_ready;
    logic [XW+YW+ZW-1:0] req_xyz;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [ZW-1:0]       z;
    logic [MASKW-1:0]    edge_mask;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [BEATW-1:0]    rsp_data;
    logic [3:0]          rsp_idx;
    logic                rsp_last;
    logic [9:0]          hit_cnt;
    logic                hit_valid;

    int checks   = 0;
    int failures = 0;

    prm_mask_responder #(
        .XW(XW), .YW(YW), .ZW(ZW), .MASKW(MASKW), .BEATW(BEATW), .SETTLE(SETTLE)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_xyz(req_xyz),
        .x(x), .y(y), .z(z), .edge_mask(edge_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_idx(rsp_idx), .rsp_last(rsp_last),
        .hit_cnt(hit_cnt), .hit_valid(hit_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_xyz(input string tag, input logic [13:0] xyz);
        check({tag, "_x"}, 32'(x), 32'(xyz >> 10));
        check({tag, "_y"}, 32'(y), 32'((xyz >> 5) & 14'h1F));
        check({tag, "_z"}, 32'(z), 32'(xyz & 14'h1F));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_data"},  rsp_data, 0);
        check({tag, "_rsp_idx"},   32'(rsp_idx), 0);
        check({tag, "_rsp_last"},  32'(rsp_last), 0);
        check({tag, "_hit_cnt"},   32'(hit_cnt), 0);
        check({tag, "_hit_valid"}, 32'(hit_valid), 0);
        check_xyz(tag, 14'h0);
    endtask

    function automatic logic [MASKW-1:0] random_mask();
        logic [MASKW-1:0] m;
        for (int w = 0; w < NB; w++) m[w*BEATW +: BEATW] = $urandom;
        return m;
    endfunction

    // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
    task automatic run_txn(input logic [13:0] xyz, input logic [MASKW-1:0] mask,
                           input int ready_mode, input bit drop_mask,
                           input bit busy_req, input int reset_at);
        logic [MASKW-1:0] shifted;
        logic [31:0]      exp_beat;
        int               exp_pop;
        int               cyc;
        int               k;
        int               guard;
        int               pat[4];
        bit               r;
        bit               aborted;
        pat     = '{1, 0, 0, 1};
        exp_pop = $countones(mask);
        aborted = 0;

        @(negedge CLK);
        check("idle_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_xyz   = xyz;
        edge_mask = mask;
        rsp_ready = 1'b0;

        @(negedge CLK);
        cyc       = 1;
        req_valid = 1'b0;
        req_xyz   = 14'($urandom);
        check_xyz("accept", xyz);
        check("busy_ready", 32'(req_ready), 0);
        check("settle_valid", 32'(rsp_valid), 0);
        while (cyc < SETTLE) begin
            @(negedge CLK);
            cyc++;
            check("settle_valid", 32'(rsp_valid), 0);
        end

        k = 0;
        guard = 0;
        while (k < NB && guard < 400) begin
            @(negedge CLK);
            cyc++;
            guard++;
            if (drop_mask && cyc == SETTLE + 1) edge_mask = '0;
            shifted  = mask >> (BEATW * k);
            exp_beat = shifted[31:0];
            check("rsp_valid", 32'(rsp_valid), 1);
            check("rsp_idx",   32'(rsp_idx), 32'(k));
            check("rsp_data",  rsp_data, exp_beat);
            check("rsp_last",  32'(rsp_last), 32'(k == NB - 1));
            check("send_hit_valid", 32'(hit_valid), 0);
            if (busy_req) begin
                check("busy_req_ready", 32'(req_ready), 0);
                check_xyz("busy_hold", xyz);
                req_valid = 1'b1;
                req_xyz   = ~xyz;
            end
            if (k == reset_at) begin
                #1 RST = 1'b1;
                #1 check_all_zero("midreset");
                @(negedge CLK);
                RST = 1'b0;
                #1 check("post_reset_ready", 32'(req_ready), 1);
                aborted = 1;
                break;
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = pat[(guard - 1) % 4] != 0;
                default: r = $urandom_range(0, 1) != 0;
            endcase
            rsp_ready = r;
            if (r) k++;
        end

        if (aborted) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                check("abort_hit_valid", 32'(hit_valid), 0);
                check("abort_hit_cnt",   32'(hit_cnt), 0);
                check("abort_rsp_valid", 32'(rsp_valid), 0);
            end
            return;
        end
        check("send_complete", 32'(k), 32'(NB));

        @(negedge CLK);
        cyc++;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("done_hit_valid", 32'(hit_valid), 1);
        check("done_hit_cnt",   32'(hit_cnt), 32'(exp_pop));
        check("done_rsp_valid", 32'(rsp_valid), 0);
        if (ready_mode == 0) check("done_cycle", 32'(cyc), 32'(SETTLE + NB + 1));

        @(negedge CLK);
        check("after_hit_valid", 32'(hit_valid), 0);
        check("after_ready",     32'(req_ready), 1);
        check("after_hit_cnt",   32'(hit_cnt), 32'(exp_pop));
        check_xyz("after_hold", xyz);
    endtask

    initial begin
        logic [MASKW-1:0] m;
        RST       = 1'b1;
        req_valid = 1'b0;
        req_xyz   = '0;
        edge_mask = '0;
        rsp_ready = 1'b0;

        #3 check_all_zero("reset");
        @(negedge CLK);
        RST = 1'b0;
        #1 check("release_ready", 32'(req_ready), 1);

        run_txn(14'h1ABC, {MASKW{1'b1}}, 0, 0, 0, -1);

        for (int k = 0; k < NB; k++) m[k*BEATW +: BEATW] = 32'(k);
        run_txn(14'h0123, m, 0, 0, 0, -1);

        run_txn(14'($urandom), random_mask(), 1, 0, 0, -1);
        run_txn(14'($urandom), random_mask(), 0, 1, 1, -1);
        run_txn(14'($urandom), random_mask(), 0, 0, 0, 7);
        run_txn(14'($urandom), '0, 0, 0, 0, -1);

        for (int t = 0; t < 4; t++) begin
            run_txn(14'($urandom), random_mask(), 2, t[0], t[1], -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
